imem_fetch_arbiter: RTL

Shared instruction-fetch responder between the SIMD cores and the single instruction-memory port. Each core raises a fetch request carrying its PC. The block arbitrates round-robin and forwards one request at a time to imem. It returns the fetched word to the requesting core with a one-cycle valid pulse. It is the serving end of the per-core `instruction_fetch` / `instruction_from_imem` path.

---
 rtl/imem_fetch_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/imem_fetch_arbiter.sv
// imem_fetch_arbiter
//
// Shared instruction-fetch responder between the SIMD cores and the single
// instruction-memory port. Requests are arbitrated round-robin, one imem
// transaction is outstanding at a time, and the fetched word is returned to
// the requesting core with a one-cycle valid pulse.
//
// Optional feature: define IMEM_FETCH_LINE_BUF_EN to add a one-entry line
// buffer {valid, tag_pc, word}. A request whose aligned PC matches a valid
// tag is answered without touching imem. `flush` invalidates the buffer; it
// is ignored when the buffer is compiled out.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-low reset
//   fetch_req    per-core request level
//   fetch_pc     per-core fetch address
//   fetch_valid  one-hot, one-cycle response pulse
//   fetch_instr  fetched word, broadcast, qualified by fetch_valid
//   imem_req     memory request
//   imem_addr    memory word address (bits [1:0] always 0)
//   imem_gnt     memory accepts the request
//   imem_rvalid  read data valid
//   imem_rdata   read data
//   flush        invalidate line buffer

module imem_fetch_arbiter #(
  parameter int unsigned NUM_SIMD_CORES  = 4,
  parameter int unsigned LOG2_SIMD_CORES = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_SIMD_CORES-1:0]        fetch_req,
  input  logic [NUM_SIMD_CORES-1:0][31:0]  fetch_pc,
  output logic [NUM_SIMD_CORES-1:0]        fetch_valid,
  output logic [31:0]                      fetch_instr,
  output logic                             imem_req,
  output logic [31:0]                      imem_addr,
  input  logic                             imem_gnt,
  input  logic                             imem_rvalid,
  input  logic [31:0]                      imem_rdata,
  input  logic                             flush
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e                     state_q;
  logic [LOG2_SIMD_CORES-1:0] rr_ptr_q;
  logic [LOG2_SIMD_CORES-1:0] cur_id_q;
  logic [31:0]                cur_pc_q;
  logic [31:0]                data_q;

  // fetch_instr only changes when data_q is loaded on entry to StResp, so it
  // naturally holds its last value outside the response cycle.
  assign fetch_instr = data_q;
  // cur_pc_q is only loaded in StIdle and is stable through StReq.
  assign imem_addr   = cur_pc_q;

  function automatic logic [NUM_SIMD_CORES-1:0] id_onehot(input logic [LOG2_SIMD_CORES-1:0] id);
    return NUM_SIMD_CORES'(1) << id;
  endfunction

  // Round-robin pick: first requester at or above rr_ptr_q, wrapping.
  logic [LOG2_SIMD_CORES-1:0] win_id;
  logic [LOG2_SIMD_CORES-1:0] scan_id;
  logic                       win_found;
  logic [31:0]                win_pc;

  always_comb begin
    win_id    = rr_ptr_q;
    win_found = 1'b0;
    scan_id   = '0;
    for (int unsigned i = 0; i < NUM_SIMD_CORES; i++) begin
      scan_id = LOG2_SIMD_CORES'((32'(rr_ptr_q) + i) % NUM_SIMD_CORES);
      if (!win_found && fetch_req[scan_id]) begin
        win_found = 1'b1;
        win_id    = scan_id;
      end
    end
    win_pc = {fetch_pc[win_id][31:2], 2'b00};
  end

  logic [LOG2_SIMD_CORES-1:0] rr_next;
  assign rr_next = (cur_id_q == LOG2_SIMD_CORES'(NUM_SIMD_CORES - 1)) ? '0 : cur_id_q + 1'b1;

  // Low address bits are dropped by alignment.
  logic unused_pc_lo;
  always_comb begin
    unused_pc_lo = 1'b0;
    for (int unsigned i = 0; i < NUM_SIMD_CORES; i++) begin
      unused_pc_lo = unused_pc_lo ^ (^fetch_pc[i][1:0]);
    end
  end

  logic        buf_hit;
  logic [31:0] buf_word;

`ifdef IMEM_FETCH_LINE_BUF_EN
  logic        buf_valid_q;
  logic [31:0] buf_tag_q;
  logic [31:0] buf_word_q;

  assign buf_hit  = buf_valid_q && (buf_tag_q == win_pc);
  assign buf_word = buf_word_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_word_q  <= '0;
    end else if (state_q == StWait && imem_rvalid) begin
      // A flush coinciding with the fill leaves the entry invalid.
      buf_valid_q <= !flush;
      buf_tag_q   <= cur_pc_q;
      buf_word_q  <= imem_rdata;
    end else if (flush) begin
      buf_valid_q <= 1'b0;
    end
  end
`else
  assign buf_hit  = 1'b0;
  assign buf_word = '0;

  logic unused_flush;
  assign unused_flush = flush;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      cur_id_q    <= '0;
      cur_pc_q    <= '0;
      data_q      <= '0;
      fetch_valid <= '0;
      imem_req    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            cur_id_q <= win_id;
            cur_pc_q <= win_pc;
            if (buf_hit) begin
              data_q      <= buf_word;
              fetch_valid <= id_onehot(win_id);
              state_q     <= StResp;
            end else begin
              imem_req <= 1'b1;
              state_q  <= StReq;
            end
          end
        end
        StReq: begin
          if (imem_gnt) begin
            imem_req <= 1'b0;
            state_q  <= StWait;
          end
        end
        StWait: begin
          if (imem_rvalid) begin
            data_q      <= imem_rdata;
            fetch_valid <= id_onehot(cur_id_q);
            state_q     <= StResp;
          end
        end
        StResp: begin
          fetch_valid <= '0;
          rr_ptr_q    <= rr_next;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
